// File: rtl/key_debounce_irq_ctrl.sv
// Per-key synchronize + debounce with edge capture, Avalon-MM register window and level irq.
// Read latency 1 cycle; slave never stalls the bus, so there is no backpressure.
module key_debounce_irq_ctrl #(
    parameter int NUM_KEYS  = 4,
    parameter int DB_CYCLES = 50000
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [1:0]          address,
    input  logic                chipselect,
    input  logic                write_n,
    input  logic [31:0]         writedata,
    output logic [31:0]         readdata,
    input  logic [NUM_KEYS-1:0] in_port,
    output logic                irq
);
    localparam logic [15:0] LAST = 16'(DB_CYCLES - 1);

    logic [NUM_KEYS-1:0] sync1, sync2;
    logic [NUM_KEYS-1:0] db;
    logic [15:0]         cnt [NUM_KEYS];
    logic [NUM_KEYS-1:0] rise_sel, fall_sel;
    logic [NUM_KEYS-1:0] irq_mask;
    logic [NUM_KEYS-1:0] edge_cap;

    logic                wr_en;
    logic [NUM_KEYS-1:0] db_upd;
    logic [NUM_KEYS-1:0] edge_set;
    logic [NUM_KEYS-1:0] cap_clr;
    logic [31:0]         rd_mux;
    logic                unused_wdata;

    assign wr_en        = chipselect & ~write_n;
    assign unused_wdata = ^writedata;

    always_comb begin
        db_upd = '0;
        for (int i = 0; i < NUM_KEYS; i++) begin
            db_upd[i] = (sync2[i] != db[i]) && (cnt[i] == LAST);
        end
        edge_set = (db_upd & sync2 & rise_sel) | (db_upd & ~sync2 & fall_sel);
        cap_clr  = (wr_en && address == 2'd3) ? writedata[NUM_KEYS-1:0] : '0;
    end

    always_comb begin
        rd_mux = '0;
        case (address)
            2'd0: rd_mux[NUM_KEYS-1:0] = db;
            2'd1: begin
                rd_mux[NUM_KEYS-1:0]  = rise_sel;
                rd_mux[16 +: NUM_KEYS] = fall_sel;
            end
            2'd2: rd_mux[NUM_KEYS-1:0] = irq_mask;
            default: rd_mux[NUM_KEYS-1:0] = edge_cap;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1 <= '0;
            sync2 <= '0;
            db    <= '0;
            for (int i = 0; i < NUM_KEYS; i++) cnt[i] <= '0;
        end else begin
            sync1 <= in_port;
            sync2 <= sync1;
            for (int i = 0; i < NUM_KEYS; i++) begin
                if (sync2[i] == db[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == LAST) begin
                    db[i]  <= sync2[i];
                    cnt[i] <= '0;
                end else begin
                    cnt[i] <= cnt[i] + 16'd1;
                end
            end
        end
    end

    // A capture landing on the same edge as a W1C clear must survive, so set is OR'd last.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rise_sel <= '0;
            fall_sel <= '0;
            irq_mask <= '0;
            edge_cap <= '0;
            readdata <= '0;
        end else begin
            if (wr_en && address == 2'd1) begin
                rise_sel <= writedata[NUM_KEYS-1:0];
                fall_sel <= writedata[16 +: NUM_KEYS];
            end
            if (wr_en && address == 2'd2) irq_mask <= writedata[NUM_KEYS-1:0];
            edge_cap <= (edge_cap & ~cap_clr) | edge_set;
            readdata <= rd_mux;
        end
    end

    assign irq = |(edge_cap & irq_mask);

endmodule
